// File: rtl/nonce_selector.sv
// Scans NUM_NONCES per-nonce hash words from a synchronous-read memory and
// reports the smallest hash below target, its nonce and the number of passes.
module nonce_selector #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic        found,
    output logic [7:0]  best_nonce,
    output logic [31:0] best_hash,
    output logic [7:0]  match_count
);

    localparam logic [7:0] LP_NUM = 8'(NUM_NONCES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_SCAN,
        ST_REPORT
    } state_t;

    state_t      r_state;
    logic [15:0] r_base;
    logic [31:0] r_target;
    logic [7:0]  r_idx;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_work_count;
    logic [7:0]  r_work_nonce;
    logic [31:0] r_work_hash;
    logic        r_found;
    logic [7:0]  r_best_nonce;
    logic [31:0] r_best_hash;
    logic [7:0]  r_match_count;

    logic [7:0]  w_next_idx;
    logic [7:0]  w_cur_nonce;
    logic        w_pass;
    logic        w_better;

    assign w_next_idx  = r_idx + 8'd1;
    assign w_cur_nonce = r_idx - 8'd1;
    assign w_pass      = (mem_read_data < r_target);
    // Strictly-less keeps the earlier (lower) nonce on equal hashes.
    assign w_better    = w_pass && (mem_read_data < r_work_hash);

    // mem_addr is registered one state ahead so the word for nonce idx-1
    // arrives exactly in the SCAN cycle that evaluates it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_base        <= 16'd0;
            r_target      <= 32'd0;
            r_idx         <= 8'd0;
            r_mem_addr    <= 16'd0;
            r_work_count  <= 8'd0;
            r_work_nonce  <= 8'd0;
            r_work_hash   <= 32'hFFFF_FFFF;
            r_found       <= 1'b0;
            r_best_nonce  <= 8'd0;
            r_best_hash   <= 32'hFFFF_FFFF;
            r_match_count <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_base       <= hash_addr;
                        r_target     <= target;
                        r_idx        <= 8'd0;
                        r_work_count <= 8'd0;
                        r_work_nonce <= 8'd0;
                        r_work_hash  <= 32'hFFFF_FFFF;
                        r_mem_addr   <= hash_addr;
                        r_state      <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    r_idx      <= 8'd1;
                    r_mem_addr <= (8'd1 < LP_NUM) ? (r_base + 16'd1) : 16'd0;
                    r_state    <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (w_pass) begin
                        r_work_count <= r_work_count + 8'd1;
                    end
                    if (w_better) begin
                        r_work_hash  <= mem_read_data;
                        r_work_nonce <= w_cur_nonce;
                    end
                    if (r_idx < LP_NUM) begin
                        r_idx      <= w_next_idx;
                        r_mem_addr <= (w_next_idx < LP_NUM) ? (r_base + {8'd0, w_next_idx}) : 16'd0;
                    end else begin
                        r_mem_addr <= 16'd0;
                        r_state    <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    r_found       <= (r_work_count != 8'd0);
                    r_best_nonce  <= r_work_nonce;
                    r_best_hash   <= r_work_hash;
                    r_match_count <= r_work_count;
                    r_idx         <= 8'd0;
                    r_mem_addr    <= 16'd0;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign done        = (r_state == ST_IDLE);
    assign mem_clk     = clk;
    assign mem_we      = 1'b0;
    assign mem_addr    = r_mem_addr;
    assign found       = r_found;
    assign best_nonce  = r_best_nonce;
    assign best_hash   = r_best_hash;
    assign match_count = r_match_count;

endmodule

// File: doc/nonce_selector.md
NONCE_SELECTOR -- requirements
Module: nonce_selector

Interface
REQ-001 SHALL have parameter NUM_NONCES, default 16, number of per-nonce hash words scanned per run (legal range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port start  input  1  request to begin a scan; honoured only in IDLE.
REQ-005 SHALL have port hash_addr  input  16  base word address of hash H0 words, nonce n at hash_addr+n.
REQ-006 SHALL have port target  input  32  difficulty threshold, unsigned.
REQ-007 SHALL have port done  output  1  high exactly while FSM is in IDLE.
REQ-008 SHALL have port mem_clk  output  1  equal to clk.
REQ-009 SHALL have port mem_we  output  1  write enable, constant 0.
REQ-010 SHALL have port mem_addr  output  16  memory read address.
REQ-011 SHALL have port mem_read_data  input  32  memory data, valid the cycle after its address is presented.
REQ-012 SHALL have ports found (output, 1), best_nonce (output, 8), best_hash (output, 32) and match_count (output, 8) carrying the result of the last completed scan.

Function
REQ-013 SHALL implement FSM states IDLE, PRIME, SCAN, REPORT.
REQ-014 IDLE with start=1 SHALL latch hash_addr and target, clear the working regs, set idx=0 and go to PRIME; start outside IDLE SHALL be ignored.
REQ-015 PRIME SHALL drive mem_addr=base+0, set idx=1 and go to SCAN.
REQ-016 SCAN SHALL evaluate mem_read_data as the hash of nonce idx-1 and, while idx<NUM_NONCES, drive mem_addr=base+idx and increment idx.
REQ-017 SCAN SHALL go to REPORT in the cycle it evaluates nonce NUM_NONCES-1.
REQ-018 REPORT SHALL copy the working regs to the result outputs and return to IDLE.
REQ-019 Result outputs SHALL change only in REPORT or on reset, and SHALL hold their values across later scans until the next REPORT.
REQ-020 Address arithmetic SHALL be 16-bit modulo 2^16, e.g. base 16'hFFFF, idx 1 gives 16'h0000.
REQ-021 mem_addr SHALL be 16'h0000 in IDLE and REPORT.
REQ-022 A hash SHALL pass when it is less than target (unsigned, strict); hash==target SHALL fail.
REQ-023 match_count SHALL equal the number of passing nonces; it cannot saturate given the parameter range.
REQ-024 best_hash/best_nonce SHALL be the minimum passing hash and its nonce; on a tie the lower nonce SHALL be kept.
REQ-025 found SHALL be 1 if and only if match_count is nonzero.
REQ-026 With no passing hash, REPORT SHALL set best_hash=32'hFFFFFFFF, best_nonce=0 and found=0.
REQ-027 Latency SHALL be fixed: start accepted at cycle T gives REPORT at T+NUM_NONCES+2 and done=1 at T+NUM_NONCES+3.
REQ-028 With NUM_NONCES=1, SCAN SHALL last one cycle.
REQ-029 start held high continuously SHALL begin a new scan on the first IDLE cycle after each REPORT.

Reset
REQ-030 reset=1 SHALL force IDLE from any state, including mid-scan, and the aborted scan SHALL produce no REPORT.
REQ-031 Reset values SHALL be done=1, mem_we=0, mem_addr=0, found=0, best_nonce=0, best_hash=32'hFFFFFFFF, match_count=0, idx=0.
REQ-032 reset SHALL take priority over start when both are high in the same cycle.

Verification
REQ-033 The bench SHALL apply NUM_NONCES=16, base=16'h0020, target=32'h00010000, words at 0x20..0x2F = 32'hFFFFFFFF except nonce 5=32'h00008000 and nonce 9=32'h00000100, and SHALL check found=1, match_count=2, best_nonce=9, best_hash=32'h00000100, done returning at T+19.
REQ-034 The bench SHALL apply all words = 32'h00010000 with target 32'h00010000, and SHALL check found=0, match_count=0, best_hash=32'hFFFFFFFF.
REQ-035 The bench SHALL apply nonces 3 and 12 both 32'h00000010 with target 32'h00001000, and SHALL check best_nonce=3, match_count=2.
REQ-036 The bench SHALL apply base=16'hFFF8, and SHALL check the mem_addr sequence 16'hFFF8..16'hFFFF, 16'h0000..16'h0007, with mem_we=0 throughout.
REQ-037 The bench SHALL complete a scan, assert reset at SCAN idx=7 of a second scan, and SHALL check that all outputs take reset values at the next edge and done=1.
REQ-038 The bench SHALL pulse start during SCAN, and SHALL check that it is ignored: scan length unchanged and no second scan.
